// File: rtl/sin_diff_nco.sv
// Multi-channel differential NCO stimulus source for SAR-ADC behavioural benches.
// One shared phase accumulator drives NCH channels, each with its own phase offset.
module sin_diff_nco #(
  parameter int  NCH     = 2,
  parameter int  PHASE_W = 16,
  parameter int  CNT_W   = 16,
  parameter real AMP     = 0.5,
  parameter real DC      = 0.5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic [PHASE_W-1:0]     fcw,
  input  logic [NCH*PHASE_W-1:0] phase_ofs,
  input  logic [CNT_W-1:0]       burst_len,
  output logic                   busy,
  output logic                   sample_valid,
  output logic                   done,
  output logic [CNT_W-1:0]       sample_cnt,
  output real                    sin_vop [NCH],
  output real                    sin_von [NCH]
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam real             PI      = 3.14159265358979323846;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                   r_state, w_next;
  logic [PHASE_W-1:0]       r_acc;
  logic [CNT_W-1:0]         r_cnt, w_cnt_next;
  logic [1:0]               r_mode;
  logic [PHASE_W-1:0]       r_fcw;
  logic [NCH*PHASE_W-1:0]   r_ofs;
  logic [CNT_W-1:0]         r_burst;
  logic                     r_valid, r_done;
  logic                     w_sample, w_launch;
  logic [PHASE_W-1:0]       w_th [NCH];

  // Normalised waveform value s in [-1,1] for phase th of one period.
  function automatic real f_wave(input logic [1:0] m, input logic [PHASE_W-1:0] th);
    real x;
    real s;
    x = real'(th) / (2.0 ** PHASE_W);
    case (m)
      2'd0:    s = $sin(2.0 * PI * x);
      2'd1:    s = (x < 0.5) ? (4.0 * x - 1.0) : (3.0 - 4.0 * x);
      2'd2:    s = 0.0;
      default: s = th[PHASE_W-1] ? -1.0 : 1.0;
    endcase
    return s;
  endfunction

  always_comb begin
    for (int i = 0; i < NCH; i++) w_th[i] = r_acc + r_ofs[i*PHASE_W +: PHASE_W];
  end

  // Counter saturates so a long continuous run never wraps back to zero.
  assign w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + CNT_ONE;
  assign w_launch   = (r_state == S_IDLE) && start && !stop;
  assign w_sample   = (r_state == S_RUN) && !stop;

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_launch) w_next = S_RUN;
      S_RUN: begin
        if (stop)                                          w_next = S_IDLE;
        else if (r_burst != '0 && w_cnt_next == r_burst)   w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_mode  <= '0;
      r_fcw   <= '0;
      r_ofs   <= '0;
      r_burst <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        sin_vop[i] <= DC;
        sin_von[i] <= DC;
      end
    end else begin
      r_state <= w_next;
      r_valid <= w_sample;
      r_done  <= (r_state == S_DONE);
      if (w_launch) begin
        r_mode  <= mode;
        r_fcw   <= fcw;
        r_ofs   <= phase_ofs;
        r_burst <= burst_len;
        r_acc   <= '0;
        r_cnt   <= '0;
      end
      if (w_sample) begin
        for (int i = 0; i < NCH; i++) begin
          sin_vop[i] <= DC + AMP * f_wave(r_mode, w_th[i]);
          sin_von[i] <= DC - AMP * f_wave(r_mode, w_th[i]);
        end
        r_acc <= r_acc + r_fcw;
        r_cnt <= w_cnt_next;
      end
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign sample_valid = r_valid;
  assign done         = r_done;
  assign sample_cnt   = r_cnt;

endmodule

// File: tb/tb_sin_diff_nco.sv
// Randomised scoreboard bench for sin_diff_nco: stimulus pushes expected samples,
// a negedge monitor pops and compares whenever sample_valid is high.
module tb_sin_diff_nco;

  localparam int  NCH = 2;
  localparam real AMP = 0.5;
  localparam real DC  = 0.5;
  localparam real PI  = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic [1:0]  mode;
  logic [15:0] fcw;
  logic [31:0] phase_ofs;
  logic [15:0] burst_len;
  logic        busy, sample_valid, done;
  logic [15:0] sample_cnt;
  real         sin_vop [NCH];
  real         sin_von [NCH];

  int n_vec  = 0;
  int n_bad  = 0;
  real q_s0 [$];
  real q_s1 [$];
  int  q_cnt[$];

  sin_diff_nco #(.NCH(NCH), .PHASE_W(16), .CNT_W(16), .AMP(AMP), .DC(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .fcw(fcw),
    .phase_ofs(phase_ofs), .burst_len(burst_len), .busy(busy), .sample_valid(sample_valid),
    .done(done), .sample_cnt(sample_cnt), .sin_vop(sin_vop), .sin_von(sin_von)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_r(input string nm, input real act, input real exp);
    n_vec++;
    if (act - exp > 1e-6 || exp - act > 1e-6) begin
      n_bad++;
      $display("FAIL %s: got %f expected %f", nm, act, exp);
    end
  endtask

  // Reference waveform straight from the definition, phase given in 1/65536 periods.
  function automatic real ref_s(input int m, input longint phase);
    real x;
    x = real'(phase % 65536) / 65536.0;
    case (m)
      0:       return $sin(2.0 * PI * x);
      1:       return (x < 0.5) ? 4.0 * x - 1.0 : 3.0 - 4.0 * x;
      2:       return 0.0;
      default: return (x < 0.5) ? 1.0 : -1.0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && sample_valid) begin
      if (q_cnt.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_valid: got sample_valid=1 expected 0 (no sample pending)");
      end else begin
        real s0, s1;
        int  c;
        s0 = q_s0.pop_front();
        s1 = q_s1.pop_front();
        c  = q_cnt.pop_front();
        check_r("vop0", sin_vop[0], DC + AMP * s0);
        check_r("von0", sin_von[0], DC - AMP * s0);
        check_r("vop1", sin_vop[1], DC + AMP * s1);
        check_r("von1", sin_von[1], DC - AMP * s1);
        check("sample_cnt", sample_cnt, c);
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int m, input int f, input int o0, input int o1,
                          input int len, input int nexp);
    @(negedge clk);
    mode      = 2'(m);
    fcw       = 16'(f);
    phase_ofs = {16'(o1), 16'(o0)};
    burst_len = 16'(len);
    start     = 1'b1;
    for (int n = 0; n < nexp; n++) begin
      q_s0.push_back(ref_s(m, longint'(n) * f + o0));
      q_s1.push_back(ref_s(m, longint'(n) * f + o1));
      q_cnt.push_back(n + 1);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check("valid_at_start_edge", sample_valid, 0);
  endtask

  task automatic finish_burst(input int len);
    for (int k = 1; k <= len; k++) begin
      wait_edges(1);
      check("burst_valid", sample_valid, 1);
      check("burst_busy", busy, 1);
      check("burst_done_early", done, 0);
    end
    wait_edges(1);
    check("end_valid", sample_valid, 0);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_cnt", sample_cnt, len);
    wait_edges(1);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    real hold0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    mode = '0; fcw = '0; phase_ofs = '0; burst_len = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_done", done, 0);
    check("rst_cnt", sample_cnt, 0);
    check_r("rst_vop0", sin_vop[0], DC);
    check_r("rst_von1", sin_von[1], DC);
    @(negedge clk);
    rst_n = 1'b1;

    // Sine quarter steps: 0.5, 1.0, 0.5, 0.0.
    do_start(0, 16384, 0, 0, 4, 4);
    wait_edges(1);
    wait_edges(1);
    check_r("t1_vop_s1", sin_vop[0], 1.0);
    check_r("t1_von_s1", sin_von[0], 0.0);
    wait_edges(2);
    check_r("t1_vop_s3", sin_vop[0], 0.0);
    wait_edges(1);
    check("t1_done", done, 1);
    check("t1_cnt", sample_cnt, 4);
    wait_edges(2);

    // Channel 1 leads channel 0 by a quarter period.
    do_start(0, 16384, 0, 16384, 4, 4);
    wait_edges(1);
    check_r("t2_ch1_s0", sin_vop[1], 1.0);
    check_r("t2_ch0_s0", sin_vop[0], 0.5);
    wait_edges(5);

    // Accumulator wrap, square, triangle.
    do_start(0, 40000, 0, 0, 10, 10);
    finish_burst(10);
    do_start(3, 8192, 0, 8192, 8, 8);
    finish_burst(8);
    do_start(1, 16384, 0, 0, 4, 4);
    wait_edges(1);
    check_r("t4_tri_s0", sin_vop[0], 0.0);
    wait_edges(2);
    check_r("t4_tri_s2", sin_vop[0], 1.0);
    wait_edges(3);

    // Randomised bursts.
    for (int it = 0; it < 8; it++) begin
      int m, f, o0, o1, len;
      m   = int'($urandom_range(0, 3));
      f   = int'($urandom_range(0, 65535));
      o0  = int'($urandom_range(0, 65535));
      o1  = int'($urandom_range(0, 65535));
      len = int'($urandom_range(1, 12));
      do_start(m, f, o0, o1, len, len);
      finish_burst(len);
    end

    // Continuous run stopped after 7 samples.
    do_start(0, 1000, 123, 456, 0, 7);
    wait_edges(7);
    check("t5_cnt7", sample_cnt, 7);
    stop = 1'b1;
    wait_edges(1);
    stop = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_valid", sample_valid, 0);
    check("t5_done", done, 0);
    check("t5_cnt_hold", sample_cnt, 7);
    hold0 = DC + AMP * ref_s(0, 6 * 1000 + 123);
    wait_edges(2);
    check("t5_done_late", done, 0);
    check_r("t5_hold_s6", sin_vop[0], hold0);
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    check("t5_startstop_idle", busy, 0);
    wait_edges(2);
    check("t5_startstop_novalid", sample_valid, 0);
    check("t5_startstop_cnt", sample_cnt, 7);

    // Asynchronous reset between edges, mid-burst.
    do_start(1, 3000, 0, 0, 20, 5);
    wait_edges(5);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_r("t6_rst_vop0", sin_vop[0], DC);
    check_r("t6_rst_von0", sin_von[0], DC);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", sample_valid, 0);
    check("t6_rst_cnt", sample_cnt, 0);
    wait_edges(2);
    check("t6_rst_no_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(0, 16384, 0, 16384, 3, 3);
    finish_burst(3);

    wait_edges(2);
    check("queue_drained", q_cnt.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
